dir_cmd_encoder: RTL and testbench

- Front end for the direction buttons; converts them into the 2-bit direction commands that the game-logic block consumes.
- Per button: synchronises, debounces and edge-detects the four raw buttons.
- Rejects illegal turns (reversal, repeat) and queues accepted turns in a small FIFO.
- Releases exactly one queued turn per movement tick, so fast presses between ticks are not lost.
- Sits between the board push-buttons and the snake game-logic block.

---
 rtl/snake_pkg.sv | 17 +
 rtl/dir_cmd_encoder_if.sv | 15 +
 rtl/btn_debounce.sv | 39 +++
 rtl/dir_cmd_encoder.sv | 87 ++++++++
 tb/tb_dir_cmd_encoder.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/snake_pkg.sv
// Direction encoding shared by the button front end and the snake game logic.
package snake_pkg;
  localparam logic [1:0] DIR_LEFT  = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_UP    = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam int BTN_LEFT  = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_UP    = 2;
  localparam int BTN_RIGHT = 3;
  localparam int NUM_BTNS  = 4;

  function automatic logic is_opposite(logic [1:0] a, logic [1:0] b);
    return (a ^ b) == 2'b11;
  endfunction
endpackage

// File: rtl/dir_cmd_encoder_if.sv
// Button/command bundle between the board buttons, game logic and dir_cmd_encoder.
interface dir_cmd_encoder_if #(parameter int FIFO_DEPTH = 4);
  logic [3:0]                  direction;
  logic                        game_tick;
  logic                        restart;
  logic                        clr_ovf;
  logic [1:0]                  moveway;
  logic [$clog2(FIFO_DEPTH):0] pending;
  logic                        overflow;

  modport master (output direction, game_tick, restart, clr_ovf,
                  input  moveway, pending, overflow);
  modport slave  (input  direction, game_tick, restart, clr_ovf,
                  output moveway, pending, overflow);
endinterface

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, stability counter, debounced level, registered press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic clk,
  input  logic clear,
  input  logic raw,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          level, level_d;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      sync    <= '0;
      cnt     <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
      press   <= 1'b0;
    end else begin
      sync    <= {sync[0], raw};
      level_d <= level;
      press   <= level & ~level_d;
      if (sync[1] != level) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          level <= sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end
endmodule

// File: rtl/dir_cmd_encoder.sv
// Debounced buttons -> filtered turn commands, queued and released one per game tick.
module dir_cmd_encoder
  import snake_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES = 20000,
  parameter int         FIFO_DEPTH      = 4,
  parameter logic [1:0] INIT_DIR        = 2'b11
) (
  input logic              clk,
  input logic              clear,
  dir_cmd_encoder_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [NUM_BTNS-1:0]              press;
  logic [FIFO_DEPTH-1:0][1:0]       mem;
  logic [PW-1:0]                    wptr, rptr, tail_ptr;
  logic [PW:0]                      cnt;
  logic [1:0]                       moveway, cand, ref_dir;
  logic                             overflow, cand_vld, accept, full, pop, push, drop;

  for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .clk   (clk),
      .clear (clear),
      .raw   (bus.direction[gi]),
      .press (press[gi])
    );
  end

  // Simultaneous presses: one winner, the rest are simply lost.
  always_comb begin
    cand_vld = 1'b1;
    cand     = DIR_RIGHT;
    if      (press[BTN_RIGHT]) cand = DIR_RIGHT;
    else if (press[BTN_LEFT])  cand = DIR_LEFT;
    else if (press[BTN_DOWN])  cand = DIR_DOWN;
    else if (press[BTN_UP])    cand = DIR_UP;
    else                       cand_vld = 1'b0;
  end

  assign tail_ptr = wptr - PW'(1);
  // New turns are judged against the last queued turn, not the one being executed.
  assign ref_dir  = (cnt != '0) ? mem[tail_ptr] : moveway;
  assign accept   = cand_vld && (cand != ref_dir) && !is_opposite(cand, ref_dir);
  assign full     = (cnt == (PW+1)'(FIFO_DEPTH));
  assign pop      = bus.game_tick && (cnt != '0);
  assign push     = accept && (!full || pop);
  assign drop     = accept && full && !pop;

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      mem      <= '0;
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
      moveway  <= INIT_DIR;
      overflow <= 1'b0;
    end else if (bus.restart) begin
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
      moveway  <= INIT_DIR;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        mem[wptr] <= cand;
        wptr      <= wptr + PW'(1);
      end
      if (pop) begin
        moveway <= mem[rptr];
        rptr    <= rptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + (PW+1)'(1);
        2'b01:   cnt <= cnt - (PW+1)'(1);
        default: cnt <= cnt;
      endcase
      if (drop)              overflow <= 1'b1;
      else if (bus.clr_ovf)  overflow <= 1'b0;
    end
  end

  assign bus.moveway  = moveway;
  assign bus.pending  = cnt;
  assign bus.overflow = overflow;
endmodule

// File: tb/tb_dir_cmd_encoder.sv
// Bench for dir_cmd_encoder: vector table, hand-timed corner sequences, random ops vs a queue model.
module tb_dir_cmd_encoder;
  localparam int D = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic clear = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dir_cmd_encoder_if #(.FIFO_DEPTH(DEPTH)) bus ();

  dir_cmd_encoder #(.DEBOUNCE_CYCLES(D), .FIFO_DEPTH(DEPTH), .INIT_DIR(2'b11)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  // Reference model: a queue of turns plus the current direction.
  logic [1:0] m_q[$];
  logic [1:0] m_dir = 2'b11;
  bit         m_ovf = 0;

  function automatic void m_press(logic [3:0] mask);
    logic [1:0] c, r;
    if (mask == 4'b0) return;
    if (mask[3])      c = 2'b11;
    else if (mask[0]) c = 2'b00;
    else if (mask[1]) c = 2'b01;
    else              c = 2'b10;
    r = (m_q.size() > 0) ? m_q[m_q.size()-1] : m_dir;
    if (c == r || (c ^ r) == 2'b11) return;
    if (m_q.size() >= DEPTH) m_ovf = 1;
    else m_q.push_back(c);
  endfunction

  function automatic void m_tick();
    if (m_q.size() > 0) m_dir = m_q.pop_front();
  endfunction

  function automatic void m_restart();
    m_q.delete();
    m_dir = 2'b11;
    m_ovf = 0;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(string name, int mv, int pend, int ovf);
    check({name, " moveway"},  int'(bus.moveway),  mv);
    check({name, " pending"},  int'(bus.pending),  pend);
    check({name, " overflow"}, int'(bus.overflow), ovf);
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_press(logic [3:0] mask);
    bus.direction = mask;
    cyc(D + 6);
    bus.direction = 4'b0;
    cyc(D + 6);
  endtask

  task automatic do_tick();
    bus.game_tick = 1'b1;
    cyc(1);
    bus.game_tick = 1'b0;
    cyc(1);
  endtask

  task automatic do_clr();
    bus.clr_ovf = 1'b1;
    cyc(1);
    bus.clr_ovf = 1'b0;
    cyc(1);
  endtask

  task automatic do_restart();
    bus.restart = 1'b1;
    cyc(1);
    bus.restart = 1'b0;
    cyc(1);
  endtask

  typedef enum int {OP_PRESS, OP_TICK, OP_CLR, OP_RESTART} op_t;
  typedef struct {
    op_t        op;
    logic [3:0] mask;
    int         mv;
    int         pend;
    int         ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(op_t op, logic [3:0] mask, int mv, int pend, int ovf);
    vec_t v;
    v.op = op; v.mask = mask; v.mv = mv; v.pend = pend; v.ovf = ovf;
    tbl.push_back(v);
  endfunction

  initial begin
    bus.direction = 4'b0;
    bus.game_tick = 1'b0;
    bus.restart   = 1'b0;
    bus.clr_ovf   = 1'b0;

    add(OP_RESTART, 4'b0000, 3, 0, 0);
    add(OP_PRESS,   4'b0001, 3, 0, 0);  // left: reversal
    add(OP_PRESS,   4'b1000, 3, 0, 0);  // right: repeat
    add(OP_PRESS,   4'b0100, 3, 1, 0);  // up accepted
    add(OP_PRESS,   4'b0010, 3, 1, 0);  // down vs tail up
    add(OP_TICK,    4'b0000, 2, 0, 0);
    add(OP_PRESS,   4'b0001, 2, 1, 0);
    add(OP_TICK,    4'b0000, 0, 0, 0);
    add(OP_PRESS,   4'b0010, 0, 1, 0);
    add(OP_TICK,    4'b0000, 1, 0, 0);
    add(OP_PRESS,   4'b1100, 1, 1, 0);  // right+up: right wins
    add(OP_TICK,    4'b0000, 3, 0, 0);
    add(OP_PRESS,   4'b0100, 3, 1, 0);
    add(OP_PRESS,   4'b1000, 3, 2, 0);
    add(OP_PRESS,   4'b0010, 3, 3, 0);
    add(OP_PRESS,   4'b0001, 3, 4, 0);
    add(OP_PRESS,   4'b0100, 3, 4, 1);  // dropped when full
    add(OP_CLR,     4'b0000, 3, 4, 0);
    add(OP_TICK,    4'b0000, 2, 3, 0);
    add(OP_TICK,    4'b0000, 3, 2, 0);
    add(OP_TICK,    4'b0000, 1, 1, 0);
    add(OP_TICK,    4'b0000, 0, 0, 0);

    // Reset and idle with periodic ticks
    cyc(3);
    check_all("reset", 3, 0, 0);
    clear = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(19);
      do_tick();
      check_all("idle tick", 3, 0, 0);
    end

    // Asynchronous clear with entries queued
    do_press(4'b0100);
    do_press(4'b1000);
    check("queued before clear", int'(bus.pending), 2);
    @(posedge clk);
    #2 clear = 1'b0;
    #1;
    check("async clear pending", int'(bus.pending), 0);
    check("async clear moveway", int'(bus.moveway), 3);
    cyc(2);
    clear = 1'b1;
    cyc(2);

    // 3-cycle glitch on up, then a real press with latency check
    bus.direction = 4'b0100;
    cyc(3);
    bus.direction = 4'b0000;
    cyc(12);
    check("glitch pending", int'(bus.pending), 0);
    bus.direction = 4'b0100;
    cyc(D + 3);
    check("latency minus one", int'(bus.pending), 0);
    cyc(1);
    check("latency exact", int'(bus.pending), 1);
    cyc(2);
    bus.direction = 4'b0000;
    cyc(D + 6);
    bus.game_tick = 1'b1;
    cyc(1);
    bus.game_tick = 1'b0;
    check("pop moveway", int'(bus.moveway), 2);
    cyc(1);

    // Fill the FIFO, then push coinciding with a tick
    do_press(4'b1000);
    do_press(4'b0010);
    do_press(4'b0001);
    do_press(4'b0100);
    check("full", int'(bus.pending), 4);
    bus.direction = 4'b1000;
    cyc(D + 3);
    bus.game_tick = 1'b1;
    cyc(1);
    bus.game_tick = 1'b0;
    check_all("full push+pop", 3, 4, 0);
    cyc(2);
    bus.direction = 4'b0000;
    cyc(D + 6);
    do_restart();
    check_all("restart", 3, 0, 0);

    // Empty FIFO: push and tick together leave moveway alone
    bus.direction = 4'b0100;
    cyc(D + 3);
    bus.game_tick = 1'b1;
    cyc(1);
    bus.game_tick = 1'b0;
    check_all("empty push+tick", 3, 1, 0);
    cyc(2);
    bus.direction = 4'b0000;
    cyc(D + 6);
    do_tick();
    check_all("deferred pop", 2, 0, 0);

    // Vector table
    foreach (tbl[i]) begin
      case (tbl[i].op)
        OP_PRESS:   do_press(tbl[i].mask);
        OP_TICK:    do_tick();
        OP_CLR:     do_clr();
        default:    do_restart();
      endcase
      check_all($sformatf("vec%0d", i), tbl[i].mv, tbl[i].pend, tbl[i].ovf);
    end

    // Random operations against the queue model
    do_restart();
    m_restart();
    for (int i = 0; i < 80; i++) begin
      int r;
      logic [3:0] mask;
      r = $urandom_range(0, 19);
      if (r < 11) begin
        mask = 4'($urandom_range(1, 15));
        if ($urandom_range(0, 2) != 0) mask = 4'b0001 << $urandom_range(0, 3);
        do_press(mask);
        m_press(mask);
      end else if (r < 17) begin
        do_tick();
        m_tick();
      end else if (r < 19) begin
        do_clr();
        m_ovf = 0;
      end else begin
        do_restart();
        m_restart();
      end
      check_all($sformatf("rand%0d", i), int'(m_dir), m_q.size(), int'(m_ovf));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
